// File: rtl/wb_host_initiator.sv
// rtl/wb_host_initiator.sv - Wishbone classic initiator for a cmd/rsp stream, with local project-select register
module wb_host_initiator #(
  parameter logic [31:0] CFG_ADDRESS    = 32'h300FFFFC,
  parameter int          CFG_BITS       = 2,
  parameter int          TIMEOUT_CYCLES = 255
) (
  input  logic                wb_clk_i,
  input  logic                wb_rst_i,
  input  logic                cmd_valid,
  output logic                cmd_ready,
  input  logic                cmd_we,
  input  logic [3:0]          cmd_sel,
  input  logic [31:0]         cmd_adr,
  input  logic [31:0]         cmd_dat,
  output logic                rsp_valid,
  input  logic                rsp_ready,
  output logic [31:0]         rsp_dat,
  output logic                rsp_err,
  output logic                wbm_cyc_o,
  output logic                wbm_stb_o,
  output logic                wbm_we_o,
  output logic [3:0]          wbm_sel_o,
  output logic [31:0]         wbm_adr_o,
  output logic [31:0]         wbm_dat_o,
  input  logic                wbm_ack_i,
  input  logic [31:0]         wbm_dat_i,
  output logic [CFG_BITS-1:0] cfg_o
);

  // A disabled timeout still needs a legal one-bit timer.
  localparam int TW = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
  localparam logic [TW-1:0] TMAX = TW'(TIMEOUT_CYCLES - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUS  = 2'd1,
    RESP = 2'd2
  } state_t;

  state_t        state;
  state_t        state_next;
  logic [TW-1:0] timer;
  logic          is_cfg;
  logic          expire;

  assign is_cfg = (cmd_adr == CFG_ADDRESS);
  assign expire = (TIMEOUT_CYCLES != 0) && (timer == TMAX) && !wbm_ack_i;

  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    cmd_ready  = 1'b0;
    case (state)
      IDLE: begin
        cmd_ready = 1'b1;
        if (cmd_valid) begin
          state_next = is_cfg ? RESP : BUS;
        end
      end
      BUS: begin
        if (wbm_ack_i || expire) begin
          state_next = RESP;
        end
      end
      RESP: begin
        if (rsp_ready) begin
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      rsp_valid <= 1'b0;
      rsp_dat   <= 32'h0;
      rsp_err   <= 1'b0;
      wbm_cyc_o <= 1'b0;
      wbm_stb_o <= 1'b0;
      wbm_we_o  <= 1'b0;
      wbm_sel_o <= 4'h0;
      wbm_adr_o <= 32'h0;
      wbm_dat_o <= 32'h0;
      cfg_o     <= '0;
      timer     <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (cmd_valid && is_cfg) begin
            // Project-select access is serviced here and never reaches the bus.
            if (cmd_we) begin
              cfg_o   <= cmd_dat[CFG_BITS-1:0];
              rsp_dat <= 32'h0;
            end else begin
              rsp_dat <= {{(32-CFG_BITS){1'b0}}, cfg_o};
            end
            rsp_err   <= 1'b0;
            rsp_valid <= 1'b1;
          end else if (cmd_valid) begin
            wbm_we_o  <= cmd_we;
            wbm_sel_o <= cmd_sel;
            wbm_adr_o <= cmd_adr;
            wbm_dat_o <= cmd_dat;
            wbm_cyc_o <= 1'b1;
            wbm_stb_o <= 1'b1;
            timer     <= '0;
          end
        end
        BUS: begin
          if (wbm_ack_i) begin
            wbm_cyc_o <= 1'b0;
            wbm_stb_o <= 1'b0;
            rsp_dat   <= wbm_we_o ? 32'h0 : wbm_dat_i;
            rsp_err   <= 1'b0;
            rsp_valid <= 1'b1;
          end else if (expire) begin
            wbm_cyc_o <= 1'b0;
            wbm_stb_o <= 1'b0;
            rsp_dat   <= 32'h0;
            rsp_err   <= 1'b1;
            rsp_valid <= 1'b1;
          end else begin
            timer <= timer + TW'(1);
          end
        end
        RESP: begin
          if (rsp_ready) begin
            rsp_valid <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

endmodule
